// File: rtl/ne16_output_buffer_pkg.sv
// Shared types for the NE16 output buffer: FSM state encoding, control
// and flag bundles, plus the store-length saturation helper.
package ne16_package;

  localparam int unsigned NE16_BLOCK_SIZE = 16;
  localparam int unsigned NE16_OB_NW      = 16;
  localparam int unsigned NE16_OB_AW      = $clog2(NE16_OB_NW);

  typedef enum logic [1:0] {
    OB_IDLE    = 2'd0,
    OB_CAPTURE = 2'd1,
    OB_STREAM  = 2'd2
  } state_output_buffer_t;

  typedef struct packed {
    logic                       goto_store;
    logic [NE16_OB_AW:0]        store_len;
    logic [NE16_BLOCK_SIZE-1:0] last_strb;
  } ctrl_output_buffer_t;

  typedef struct packed {
    state_output_buffer_t  state;
    logic [NE16_OB_AW-1:0] cnt;
    logic                  done;
  } flags_output_buffer_t;

  // Clamp a requested word count to the number of words actually stored.
  function automatic logic [NE16_OB_AW:0] ob_sat_len(
    input logic [NE16_OB_AW:0] len,
    input logic [NE16_OB_AW:0] nw
  );
    logic [NE16_OB_AW:0] res;
    if (len > nw) begin
      res = nw;
    end else begin
      res = len;
    end
    return res;
  endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Minimal valid/ready/data/strb stream interface used for the serialized
// output lanes.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/ne16_output_buffer_regfile.sv
// Flip-flop word store: all words written in parallel, one word read
// combinationally by address. Clear zeroes every word.
module ne16_output_buffer_regfile #(
  parameter int unsigned NW = 16,
  parameter int unsigned DS = 128,
  parameter int unsigned AW = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   we_i,
  input  logic [NW-1:0][DS-1:0]  wdata_i,
  input  logic [AW-1:0]          raddr_i,
  output logic [DS-1:0]          rdata_o
);

  logic [NW-1:0][DS-1:0] mem_r;

  // Word storage: clear wins over a parallel write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_r <= '0;
    end else if (clear_i) begin
      mem_r <= '0;
    end else if (we_i) begin
      mem_r <= wdata_i;
    end else begin
      mem_r <= mem_r;
    end
  end

  // Read port: the word currently being streamed.
  always_comb begin
    rdata_o = mem_r[raddr_i];
  end

endmodule

// File: rtl/ne16_output_buffer.sv
// NE16 output buffer: captures NW accumulator words in one shot and
// serializes them word by word onto BLOCK_SIZE parallel lanes, with a
// partial strobe on the final word.
module ne16_output_buffer
  import ne16_package::*;
#(
  parameter int unsigned NW         = 16,
  parameter int unsigned BLOCK_SIZE = NE16_BLOCK_SIZE,
  parameter int unsigned DW         = 8,
  parameter int unsigned DS         = DW * BLOCK_SIZE,
  parameter int unsigned AW         = $clog2(NW)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    test_mode_i,
  input  logic                    enable_i,
  input  logic                    clear_i,
  input  ctrl_output_buffer_t     ctrl_i,
  output flags_output_buffer_t    flags_o,
  input  logic [NW-1:0][DS-1:0]   data_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  hwpe_stream_intf_stream.source  feat_o [BLOCK_SIZE-1:0]
);

  localparam logic [AW:0] NW_LEN  = (AW+1)'(NW);
  localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

  state_output_buffer_t                 state_r;
  logic [AW-1:0]                        cnt_r;
  logic                                 done_r;
  logic [AW:0]                          len_r;
  logic [BLOCK_SIZE-1:0]                last_strb_r;

  logic [AW:0]                          len_sat_s;
  logic                                 capture_s;
  logic                                 feat_valid_s;
  logic                                 hs_s;
  logic                                 last_word_s;
  logic [DS-1:0]                        rdata_s;
  logic [BLOCK_SIZE-1:0][DW/8-1:0]      lane_strb_s;
  logic [BLOCK_SIZE-1:0]                lane_ready_unused_s;
  logic                                 unused_s;

  // Capture handshake, stream handshake (lane 0 only) and last-word decode.
  always_comb begin
    len_sat_s    = ob_sat_len(ctrl_i.store_len, NW_LEN);
    capture_s    = (state_r == OB_CAPTURE) && enable_i && valid_i;
    feat_valid_s = (state_r == OB_STREAM) && enable_i;
    hs_s         = feat_valid_s && feat_o[0].ready;
    last_word_s  = ({1'b0, cnt_r} == (len_r - LEN_ONE));
  end

  // Capture readiness follows the local enable while waiting for data.
  always_comb begin
    if (state_r == OB_CAPTURE) begin
      ready_o = enable_i;
    end else begin
      ready_o = 1'b0;
    end
  end

  // Strobe: full on every word except the last, which uses the latched mask.
  always_comb begin
    lane_strb_s = '1;
    if (last_word_s) begin
      for (int k = 0; k < BLOCK_SIZE; k++) begin
        lane_strb_s[k] = {(DW/8){last_strb_r[k]}};
      end
    end else begin
      lane_strb_s = '1;
    end
  end

  // Main FSM with word counter and one-cycle done pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= OB_IDLE;
      cnt_r       <= '0;
      done_r      <= 1'b0;
      len_r       <= '0;
      last_strb_r <= '0;
    end else if (clear_i) begin
      state_r     <= OB_IDLE;
      cnt_r       <= '0;
      done_r      <= 1'b0;
      len_r       <= '0;
      last_strb_r <= '0;
    end else begin
      done_r <= 1'b0;
      if (enable_i) begin
        case (state_r)
          OB_IDLE: begin
            if (ctrl_i.goto_store) begin
              state_r <= OB_CAPTURE;
            end
          end
          OB_CAPTURE: begin
            if (capture_s) begin
              len_r       <= len_sat_s;
              last_strb_r <= ctrl_i.last_strb;
              cnt_r       <= '0;
              if (len_sat_s == '0) begin
                state_r <= OB_IDLE;
              end else begin
                state_r <= OB_STREAM;
              end
            end
          end
          OB_STREAM: begin
            if (hs_s) begin
              if (last_word_s) begin
                state_r <= OB_IDLE;
                cnt_r   <= '0;
                done_r  <= 1'b1;
              end else begin
                cnt_r <= cnt_r + AW'(1);
              end
            end
          end
          default: begin
            state_r <= OB_IDLE;
            cnt_r   <= '0;
          end
        endcase
      end
    end
  end

  ne16_output_buffer_regfile #(
    .NW (NW),
    .DS (DS),
    .AW (AW)
  ) i_regfile (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .we_i    (capture_s),
    .wdata_i (data_i),
    .raddr_i (cnt_r),
    .rdata_o (rdata_s)
  );

  for (genvar k = 0; k < BLOCK_SIZE; k++) begin : gen_lane
    assign feat_o[k].valid    = feat_valid_s;
    assign feat_o[k].data     = rdata_s[k*DW +: DW];
    assign feat_o[k].strb     = lane_strb_s[k];
    assign lane_ready_unused_s[k] = feat_o[k].ready;
  end

  // Status flags mirror the live state, counter and done pulse.
  always_comb begin
    flags_o       = '0;
    flags_o.state = state_r;
    flags_o.cnt   = cnt_r;
    flags_o.done  = done_r;
  end

  assign unused_s = ^{test_mode_i, lane_ready_unused_s};

endmodule
